// File: rtl/sram_port_arbiter_if.sv
// Master-side beat interface for sram_port_arbiter: request fields in, grant and tagged read return out.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  last;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, last, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, last, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for a single-port block RAM with burst ownership and tagged read return.
// Define SRAM_ARB_FIXED_PRIO_EN to give IDLE ties to master 0 instead of round-robin.
module sram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          PIPE_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    m0,
    sram_port_arbiter_if.slave    m1,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_pipen
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state_q, state_d;
    logic   gnt0, gnt1, pick1;
    logic   s0_vld, s0_id, tag_vld, tag_id;
    logic   rv0, rv1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign pick1 = m1.req & ~m0.req;
`else
    logic rr_q;
    assign pick1 = m1.req & (~m0.req | rr_q);

    // rr_q = 1 means master 1 wins the next IDLE tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       rr_q <= 1'b0;
        else if (state_q == IDLE && ram_en) rr_q <= gnt0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant decision; reset masks grants so the RAM is quiet while rst_n is low
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    if (pick1)       gnt1 = 1'b1;
                    else if (m0.req) gnt0 = 1'b1;
                    if (gnt0 && !m0.last) state_d = OWN0;
                    if (gnt1 && !m1.last) state_d = OWN1;
                end
            end
            OWN0: begin
                gnt0 = m0.req & rst_n;
                if (gnt0 && m0.last) state_d = IDLE;
            end
            OWN1: begin
                gnt1 = m1.req & rst_n;
                if (gnt1 && m1.last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_en   = gnt0 | gnt1;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt1) begin
            ram_we   = m1.we;
            ram_addr = m1.addr;
            ram_din  = m1.wdata;
        end else if (gnt0) begin
            ram_we   = m0.we;
            ram_addr = m0.addr;
            ram_din  = m0.wdata;
        end
    end

    // Read tag pipe: one stage matches the RAM read, a second tracks the optional output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld <= 1'b0;
            s0_id  <= 1'b0;
        end else begin
            s0_vld <= ram_en & ~ram_we;
            s0_id  <= gnt1;
        end
    end

    if (PIPE_EN) begin : g_pipe
        logic s1_vld, s1_id;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_vld <= 1'b0;
                s1_id  <= 1'b0;
            end else begin
                s1_vld <= s0_vld;
                s1_id  <= s0_id;
            end
        end
        assign tag_vld = s1_vld;
        assign tag_id  = s1_id;
    end else begin : g_nopipe
        assign tag_vld = s0_vld;
        assign tag_id  = s0_id;
    end

    assign rv0       = tag_vld & ~tag_id;
    assign rv1       = tag_vld & tag_id;
    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rv0;
    assign m1.rvalid = rv1;
    assign m0.rdata  = rv0 ? ram_dout : '0;
    assign m1.rdata  = rv1 ? ram_dout : '0;
    assign ram_pipen = PIPE_EN;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven bench for sram_port_arbiter: latency-1 and latency-2 instances with RAM models.
module tb_sram_port_arbiter;
    logic clk, rst_n;
    int   checks = 0;
    int   errors = 0;

    sram_port_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) a0 ();
    sram_port_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) a1 ();
    sram_port_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) p0 ();
    sram_port_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) p1 ();

    logic        u_en, u_we, u_pipen, q_en, q_we, q_pipen;
    logic [10:0] u_addr, q_addr;
    logic [31:0] u_din, u_dout, q_din, q_dout, q_dout1;
    logic [31:0] mem_u [2048];
    logic [31:0] mem_q [2048];

    sram_port_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .PIPE_EN(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .m0(a0), .m1(a1),
        .ram_en(u_en), .ram_we(u_we), .ram_addr(u_addr), .ram_din(u_din),
        .ram_dout(u_dout), .ram_pipen(u_pipen));

    sram_port_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .PIPE_EN(1'b1)) q_dut (
        .clk(clk), .rst_n(rst_n), .m0(p0), .m1(p1),
        .ram_en(q_en), .ram_we(q_we), .ram_addr(q_addr), .ram_din(q_din),
        .ram_dout(q_dout), .ram_pipen(q_pipen));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port RAM models; the second one adds the output register
    always @(posedge clk) begin
        if (u_en) begin
            if (u_we) mem_u[u_addr] <= u_din;
            u_dout <= mem_u[u_addr];
        end
        if (q_en) begin
            if (q_we) mem_q[q_addr] <= q_din;
            q_dout1 <= mem_q[q_addr];
        end
        q_dout <= q_dout1;
    end

    typedef struct {
        logic        req;
        logic        we;
        logic [10:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t       b0;
        beat_t       b1;
        logic        g0, g1, v0, v1;
        logic [31:0] q0, q1;
    } vec_t;

    vec_t tab_u[$];
    vec_t tab_q[$];

    function automatic beat_t nb();
        return '{1'b0, 1'b0, 11'h0, 32'h0, 1'b0};
    endfunction
    function automatic beat_t rd(input int a, input logic l);
        return '{1'b1, 1'b0, 11'(a), 32'h0, l};
    endfunction
    function automatic beat_t wr(input int a, input logic [31:0] d, input logic l);
        return '{1'b1, 1'b1, 11'(a), d, l};
    endfunction
    function automatic vec_t mk(input beat_t b0, input beat_t b1, input logic g0, input logic g1,
                                input logic v0, input logic v1, input logic [31:0] q0, input logic [31:0] q1);
        return '{b0, b1, g0, g1, v0, v1, q0, q1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input beat_t b, output logic req, output logic we,
                         output logic [10:0] addr, output logic [31:0] data, output logic last);
        req = b.req; we = b.we; addr = b.addr; data = b.data; last = b.last;
    endtask

    task automatic apply(input vec_t v, input bit pipe, input int idx);
        logic        g0, g1, v0, v1, en, we;
        logic [31:0] q0, q1, din;
        logic [10:0] addr;
        logic [10:0] ea;
        logic [31:0] ed;
        logic        ew;
        @(negedge clk);
        if (pipe) begin
            drive(v.b0, p0.req, p0.we, p0.addr, p0.wdata, p0.last);
            drive(v.b1, p1.req, p1.we, p1.addr, p1.wdata, p1.last);
        end else begin
            drive(v.b0, a0.req, a0.we, a0.addr, a0.wdata, a0.last);
            drive(v.b1, a1.req, a1.we, a1.addr, a1.wdata, a1.last);
        end
        #1;
        if (pipe) begin
            g0 = p0.gnt; g1 = p1.gnt; v0 = p0.rvalid; v1 = p1.rvalid; q0 = p0.rdata; q1 = p1.rdata;
            en = q_en; we = q_we; addr = q_addr; din = q_din;
        end else begin
            g0 = a0.gnt; g1 = a1.gnt; v0 = a0.rvalid; v1 = a1.rvalid; q0 = a0.rdata; q1 = a1.rdata;
            en = u_en; we = u_we; addr = u_addr; din = u_din;
        end
        ea = v.g1 ? v.b1.addr : (v.g0 ? v.b0.addr : 11'h0);
        ed = v.g1 ? v.b1.data : (v.g0 ? v.b0.data : 32'h0);
        ew = v.g1 ? v.b1.we   : (v.g0 ? v.b0.we   : 1'b0);
        chk($sformatf("%s%0d.gnt0", pipe ? "p" : "v", idx), 32'(g0), 32'(v.g0));
        chk($sformatf("%s%0d.gnt1", pipe ? "p" : "v", idx), 32'(g1), 32'(v.g1));
        chk($sformatf("%s%0d.rvalid0", pipe ? "p" : "v", idx), 32'(v0), 32'(v.v0));
        chk($sformatf("%s%0d.rvalid1", pipe ? "p" : "v", idx), 32'(v1), 32'(v.v1));
        chk($sformatf("%s%0d.rdata0", pipe ? "p" : "v", idx), q0, v.q0);
        chk($sformatf("%s%0d.rdata1", pipe ? "p" : "v", idx), q1, v.q1);
        chk($sformatf("%s%0d.ram_en", pipe ? "p" : "v", idx), 32'(en), 32'(v.g0 | v.g1));
        chk($sformatf("%s%0d.ram_we", pipe ? "p" : "v", idx), 32'(we), 32'(ew));
        chk($sformatf("%s%0d.ram_addr", pipe ? "p" : "v", idx), 32'(addr), 32'(ea));
        chk($sformatf("%s%0d.ram_din", pipe ? "p" : "v", idx), din, ed);
    endtask

    task automatic idle_all();
        drive(nb(), a0.req, a0.we, a0.addr, a0.wdata, a0.last);
        drive(nb(), a1.req, a1.we, a1.addr, a1.wdata, a1.last);
        drive(nb(), p0.req, p0.we, p0.addr, p0.wdata, p0.last);
        drive(nb(), p1.req, p1.we, p1.addr, p1.wdata, p1.last);
    endtask

    localparam logic [31:0] A5 = 32'hA5A5_A5A5;
    localparam logic [31:0] O1 = 32'h1111_1111;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem_u[i] = 32'h0;
            mem_q[i] = 32'h0;
        end
        u_dout = 32'h0; q_dout = 32'h0; q_dout1 = 32'h0;

        // Latency-1 instance: single beats, round-robin ties, burst ownership, read/write mixing
        tab_u.push_back(mk(wr('h010, A5, 1'b1), nb(),            1, 0, 0, 0, 0, 0));
        tab_u.push_back(mk(rd('h010, 1'b1),     nb(),            1, 0, 0, 0, 0, 0));
        tab_u.push_back(mk(nb(),                nb(),            0, 0, 1, 0, A5, 0));
        tab_u.push_back(mk(nb(),                wr('h020, O1, 1'b1), 0, 1, 0, 0, 0, 0));
`ifdef SRAM_ARB_FIXED_PRIO_EN
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h020, 1'b1), 1, 0, 0, 0, 0, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h020, 1'b1), 1, 0, 1, 0, A5, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h020, 1'b1), 1, 0, 1, 0, A5, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h020, 1'b1), 1, 0, 1, 0, A5, 0));
        tab_u.push_back(mk(nb(),            nb(),            0, 0, 1, 0, A5, 0));
`else
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h020, 1'b1), 1, 0, 0, 0, 0, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h020, 1'b1), 0, 1, 1, 0, A5, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h020, 1'b1), 1, 0, 0, 1, 0, O1));
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h020, 1'b1), 0, 1, 1, 0, A5, 0));
        tab_u.push_back(mk(nb(),            nb(),            0, 0, 0, 1, 0, O1));
`endif
        tab_u.push_back(mk(nb(),            wr('h030, 32'h30, 1'b0), 0, 1, 0, 0, 0, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), wr('h031, 32'h31, 1'b0), 0, 1, 0, 0, 0, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), nb(),                    0, 0, 0, 0, 0, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), wr('h032, 32'h32, 1'b0), 0, 1, 0, 0, 0, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), wr('h033, 32'h33, 1'b1), 0, 1, 0, 0, 0, 0));
        tab_u.push_back(mk(rd('h010, 1'b1), rd('h031, 1'b1),         1, 0, 0, 0, 0, 0));
        tab_u.push_back(mk(nb(),            rd('h031, 1'b1),         0, 1, 1, 0, A5, 0));
        tab_u.push_back(mk(nb(),            nb(),                    0, 0, 0, 1, 0, 32'h31));
        tab_u.push_back(mk(rd('h030, 1'b1), nb(),                    1, 0, 0, 0, 0, 0));
        tab_u.push_back(mk(wr('h030, 32'hDEAD_BEEF, 1'b1), nb(),     1, 0, 1, 0, 32'h30, 0));
        tab_u.push_back(mk(rd('h030, 1'b1), nb(),                    1, 0, 0, 0, 0, 0));
        tab_u.push_back(mk(nb(),            nb(),                    0, 0, 1, 0, 32'hDEAD_BEEF, 0));

        // Latency-2 instance: three reads return at T+2..T+4, data gated outside rvalid
        tab_q.push_back(mk(wr('h100, 32'd1, 1'b1), nb(), 1, 0, 0, 0, 0, 0));
        tab_q.push_back(mk(wr('h101, 32'd2, 1'b1), nb(), 1, 0, 0, 0, 0, 0));
        tab_q.push_back(mk(wr('h102, 32'd3, 1'b1), nb(), 1, 0, 0, 0, 0, 0));
        tab_q.push_back(mk(rd('h100, 1'b1),        nb(), 1, 0, 0, 0, 0, 0));
        tab_q.push_back(mk(rd('h101, 1'b1),        nb(), 1, 0, 0, 0, 0, 0));
        tab_q.push_back(mk(rd('h102, 1'b1),        nb(), 1, 0, 1, 0, 32'd1, 0));
        tab_q.push_back(mk(nb(),                   nb(), 0, 0, 1, 0, 32'd2, 0));
        tab_q.push_back(mk(nb(),                   nb(), 0, 0, 1, 0, 32'd3, 0));
        tab_q.push_back(mk(nb(),                   nb(), 0, 0, 0, 0, 0, 0));

        // Reset state with requests pending
        rst_n = 1'b0;
        idle_all();
        drive(wr('h010, A5, 1'b1), a0.req, a0.we, a0.addr, a0.wdata, a0.last);
        drive(rd('h020, 1'b1), a1.req, a1.we, a1.addr, a1.wdata, a1.last);
        #2;
        chk("rst.gnt0", 32'(a0.gnt), 0);
        chk("rst.gnt1", 32'(a1.gnt), 0);
        chk("rst.rvalid0", 32'(a0.rvalid), 0);
        chk("rst.rvalid1", 32'(a1.rvalid), 0);
        chk("rst.rdata0", a0.rdata, 0);
        chk("rst.ram_en", 32'(u_en), 0);
        chk("rst.ram_we", 32'(u_we), 0);
        chk("rst.ram_addr", 32'(u_addr), 0);
        chk("rst.ram_din", u_din, 0);
        chk("rst.pipen_u", 32'(u_pipen), 0);
        chk("rst.pipen_q", 32'(q_pipen), 1);
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;

        foreach (tab_u[i]) apply(tab_u[i], 1'b0, i);
        idle_all();
        foreach (tab_q[i]) apply(tab_q[i], 1'b1, i);
        idle_all();

        // Reset one cycle after m0 opens a burst with a read
        @(negedge clk);
        drive(rd('h010, 1'b0), a0.req, a0.we, a0.addr, a0.wdata, a0.last);
        #1;
        chk("mid.gnt0", 32'(a0.gnt), 1);
        @(negedge clk);
        drive(rd('h020, 1'b1), a1.req, a1.we, a1.addr, a1.wdata, a1.last);
        rst_n = 1'b0;
        #1;
        chk("mid.rst.gnt0", 32'(a0.gnt), 0);
        chk("mid.rst.gnt1", 32'(a1.gnt), 0);
        chk("mid.rst.ram_en", 32'(u_en), 0);
        chk("mid.rst.ram_addr", 32'(u_addr), 0);
        chk("mid.rst.rvalid0", 32'(a0.rvalid), 0);
        chk("mid.rst.rdata0", a0.rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(nb(), a0.req, a0.we, a0.addr, a0.wdata, a0.last);
        #1;
        chk("mid.rel.gnt1", 32'(a1.gnt), 1);
        chk("mid.rel.ram_addr", 32'(u_addr), 32'h020);
        chk("mid.rel.rvalid0", 32'(a0.rvalid), 0);
        @(negedge clk);
        idle_all();
        #1;
        chk("mid.ret.rvalid0", 32'(a0.rvalid), 0);
        chk("mid.ret.rvalid1", 32'(a1.rvalid), 1);
        chk("mid.ret.rdata1", a1.rdata, O1);
        @(negedge clk);
        #1;
        chk("mid.end.rvalid0", 32'(a0.rvalid), 0);
        chk("mid.end.rvalid1", 32'(a1.rvalid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
